// File: rtl/lc3_writeback.sv
// LC3 writeback stage: 8x16 register file, NZP condition codes, two async read ports.
// Optional macro WRITEBACK_BYPASS_EN forwards same-cycle write data onto the read ports.
module lc3_writeback (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_writeback,
  input  logic [1:0]  W_Control,
  input  logic [15:0] aluout,
  input  logic [15:0] memout,
  input  logic [15:0] pcout,
  input  logic [2:0]  dr,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  output logic [15:0] VSR1,
  output logic [15:0] VSR2,
  output logic [2:0]  psr
);

  logic [15:0] regfile [8];
  logic [15:0] dr_in;
  logic        write_en;
  logic [2:0]  next_psr;

  always_comb begin
    dr_in = aluout;
    case (W_Control)
      2'd0:    dr_in = aluout;
      2'd1:    dr_in = memout;
      2'd2:    dr_in = pcout;
      default: dr_in = aluout;
    endcase
  end

  // Source select 3 is reserved and simply suppresses the commit.
  assign write_en = enable_writeback && (W_Control != 2'd3);

  always_comb begin
    if (dr_in[15])
      next_psr = 3'b100;
    else if (dr_in == 16'h0000)
      next_psr = 3'b010;
    else
      next_psr = 3'b001;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++)
        regfile[i] <= 16'h0000;
      psr <= 3'b000;
    end else if (write_en) begin
      regfile[dr] <= dr_in;
      psr         <= next_psr;
    end
  end

`ifdef WRITEBACK_BYPASS_EN
  // Forward the in-flight result so execute sees it without waiting an edge.
  always_comb begin
    VSR1 = regfile[sr1];
    VSR2 = regfile[sr2];
    if (write_en && (sr1 == dr))
      VSR1 = dr_in;
    if (write_en && (sr2 == dr))
      VSR2 = dr_in;
  end
`else
  assign VSR1 = regfile[sr1];
  assign VSR2 = regfile[sr2];
`endif

endmodule

// File: tb/tb_lc3_writeback.sv
// Directed self-checking bench for lc3_writeback; honours WRITEBACK_BYPASS_EN for the same-cycle read case.
module tb_lc3_writeback;

  logic        clock;
  logic        reset;
  logic        enable_writeback;
  logic [1:0]  W_Control;
  logic [15:0] aluout;
  logic [15:0] memout;
  logic [15:0] pcout;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic [2:0]  psr;

  int testsRun = 0;
  int testsFailed = 0;
  logic [15:0] model [8];
  logic [2:0]  modelPsr;

  lc3_writeback dut (
    .clock(clock),
    .reset(reset),
    .enable_writeback(enable_writeback),
    .W_Control(W_Control),
    .aluout(aluout),
    .memout(memout),
    .pcout(pcout),
    .dr(dr),
    .sr1(sr1),
    .sr2(sr2),
    .VSR1(VSR1),
    .VSR2(VSR2),
    .psr(psr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One-cycle commit; unselected sources carry a decoy so a wrong mux choice shows up.
  task applyStimulus(input logic [1:0] ws, input logic [15:0] data, input logic [2:0] d);
    @(negedge clock);
    enable_writeback = 1'b1;
    W_Control = ws;
    aluout = ~data;
    memout = ~data;
    pcout = ~data;
    case (ws)
      2'd0: aluout = data;
      2'd1: memout = data;
      2'd2: pcout = data;
      default: aluout = data;
    endcase
    dr = d;
    @(negedge clock);
    enable_writeback = 1'b0;
    if (ws != 2'd3) begin
      model[d] = data;
      modelPsr = data[15] ? 3'b100 : (data == 16'h0000) ? 3'b010 : 3'b001;
    end
  endtask

  task readPorts(input logic [2:0] a, input logic [2:0] b);
    sr1 = a;
    sr2 = b;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    enable_writeback = 1'b0;
    W_Control = 2'd0;
    aluout = 16'h0;
    memout = 16'h0;
    pcout = 16'h0;
    dr = 3'd0;
    sr1 = 3'd0;
    sr2 = 3'd0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    modelPsr = 3'b000;

    repeat (2) @(negedge clock);
    reset = 1'b0;
    readPorts(3'd0, 3'd7);
    checkOutput("init_vsr1", VSR1, 16'h0000);
    checkOutput("init_psr", {13'b0, psr}, 16'h0000);

    // Reset after preload
    applyStimulus(2'd0, 16'h1234, 3'd3);
    readPorts(3'd3, 3'd0);
    checkOutput("preload_r3", VSR1, 16'h1234);
    checkOutput("preload_psr", {13'b0, psr}, 16'h0001);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    modelPsr = 3'b000;
    readPorts(3'd3, 3'd3);
    checkOutput("reset_r3", VSR1, 16'h0000);
    checkOutput("reset_psr", {13'b0, psr}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      readPorts(3'(i), 3'(7 - i));
      checkOutput("reset_regs", VSR1, 16'h0000);
    end

    // Source select
    applyStimulus(2'd0, 16'h00A5, 3'd2);
    readPorts(3'd2, 3'd0);
    checkOutput("alu_r2", VSR1, 16'h00A5);
    checkOutput("alu_psr", {13'b0, psr}, 16'h0001);
    applyStimulus(2'd1, 16'h8000, 3'd5);
    readPorts(3'd0, 3'd5);
    checkOutput("mem_r5", VSR2, 16'h8000);
    checkOutput("mem_psr", {13'b0, psr}, 16'h0004);
    applyStimulus(2'd2, 16'h3001, 3'd7);
    readPorts(3'd7, 3'd2);
    checkOutput("pc_r7", VSR1, 16'h3001);
    checkOutput("pc_r2_kept", VSR2, 16'h00A5);
    checkOutput("pc_psr", {13'b0, psr}, 16'h0001);

    // Zero result, reserved select, disabled cycles
    applyStimulus(2'd0, 16'h0000, 3'd4);
    readPorts(3'd4, 3'd4);
    checkOutput("zero_psr", {13'b0, psr}, 16'h0002);
    applyStimulus(2'd3, 16'hFFFF, 3'd4);
    readPorts(3'd4, 3'd0);
    checkOutput("wc3_r4", VSR1, 16'h0000);
    checkOutput("wc3_psr", {13'b0, psr}, 16'h0002);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      enable_writeback = 1'b0;
      W_Control = 2'($urandom);
      aluout = 16'($urandom);
      memout = 16'($urandom);
      pcout = 16'($urandom);
      dr = 3'($urandom);
    end
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      readPorts(3'(i), 3'(i));
      checkOutput("hold_regs", VSR1, model[i]);
    end
    checkOutput("hold_psr", {13'b0, psr}, 16'h0002);

    // Dual read
    applyStimulus(2'd0, 16'hBEEF, 3'd1);
    applyStimulus(2'd1, 16'hCAFE, 3'd6);
    readPorts(3'd1, 3'd6);
    checkOutput("dual_vsr1", VSR1, 16'hBEEF);
    checkOutput("dual_vsr2", VSR2, 16'hCAFE);
    readPorts(3'd6, 3'd6);
    checkOutput("same_vsr1", VSR1, 16'hCAFE);
    checkOutput("same_vsr2", VSR2, 16'hCAFE);

    // Same-cycle read-after-write
    applyStimulus(2'd0, 16'h0011, 3'd0);
    @(negedge clock);
    enable_writeback = 1'b1;
    W_Control = 2'd0;
    aluout = 16'h0022;
    dr = 3'd0;
    readPorts(3'd0, 3'd1);
`ifdef WRITEBACK_BYPASS_EN
    checkOutput("raw_during", VSR1, 16'h0022);
`else
    checkOutput("raw_during", VSR1, 16'h0011);
`endif
    checkOutput("raw_other_port", VSR2, 16'hBEEF);
    @(negedge clock);
    enable_writeback = 1'b0;
    #1;
    checkOutput("raw_after", VSR1, 16'h0022);

    // Back-to-back writes to one register
    @(negedge clock);
    enable_writeback = 1'b1;
    W_Control = 2'd0;
    aluout = 16'h0001;
    dr = 3'd2;
    @(negedge clock);
    aluout = 16'hFFFE;
    #1;
    checkOutput("b2b_psr1", {13'b0, psr}, 16'h0001);
    @(negedge clock);
    enable_writeback = 1'b0;
    readPorts(3'd2, 3'd0);
    checkOutput("b2b_r2", VSR1, 16'hFFFE);
    checkOutput("b2b_psr2", {13'b0, psr}, 16'h0004);

    // Reset wins over a simultaneous write
    applyStimulus(2'd0, 16'h5555, 3'd3);
    @(negedge clock);
    reset = 1'b1;
    enable_writeback = 1'b1;
    W_Control = 2'd0;
    aluout = 16'h7777;
    dr = 3'd3;
    @(negedge clock);
    reset = 1'b0;
    enable_writeback = 1'b0;
    readPorts(3'd3, 3'd6);
    checkOutput("coll_r3", VSR1, 16'h0000);
    checkOutput("coll_r6", VSR2, 16'h0000);
    checkOutput("coll_psr", {13'b0, psr}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
